multdiv_unit: RTL

Iterative signed multiply/divide unit in the execute stage, directly downstream of the instruction decoder. Consumes the decoder's `mult`/`div` strobes and the two register operands, and runs a 32-step shift-add multiply or restoring divide. Raises `busy` to stall the pipeline, then returns a 32-bit result plus an exception flag. Writeback uses the flag to redirect the destination to `$rstatus` (r30).

---
 rtl/multdiv_pkg.sv | 13 +
 rtl/multdiv_unit_div_step.sv | 25 ++
 rtl/multdiv_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit and its writeback consumer.
package multdiv_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic {OP_MULT, OP_DIV} op_t;

  // Writeback redirects the destination here when the exception flag is set.
  localparam int RSTATUS_REG = 30;

  localparam int MD_WIDTH = 32;
  localparam int CNT_W    = $clog2(MD_WIDTH);

endpackage

// File: rtl/multdiv_unit_div_step.sv
// One combinational restoring-divide iteration on unsigned magnitudes.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quot,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quot_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;

  // rem < divisor holds every step, so the WIDTH+1 bit difference never wraps.
  always_comb begin
    shifted   = {rem, quot[WIDTH-1]};
    diff      = shifted - {1'b0, divisor};
    fits      = ~diff[WIDTH];
    rem_next  = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quot_next = {quot[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply / restoring divide: WIDTH iterations on magnitudes, sign applied at DONE.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mult,
  input  logic             div,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic [WIDTH-1:0] result,
  output logic             resultRDY,
  output logic             exception,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  state_t             state;
  op_t                op;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] acc;
  logic               neg;
  logic               zero_div;

  logic               start;
  logic [WIDTH:0]     mult_sum;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quot_next;
  logic signed [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   final_res;
  logic               final_exc;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic signed [2*WIDTH-1:0] sign_wide(input logic [2*WIDTH-1:0] mag,
                                                          input logic n);
    return n ? -$signed(mag) : $signed(mag);
  endfunction

  // Product overflows when its upper half plus the result sign bit are not all equal.
  function automatic logic wide_ovf(input logic signed [2*WIDTH-1:0] p);
    logic [WIDTH:0] hi;
    hi = p[2*WIDTH-1:WIDTH-1];
    return ~((&hi) | (~|hi));
  endfunction

  assign start = (state == IDLE) & (mult ^ div);
  assign busy  = reset & ((state != IDLE) | start);

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem       (acc[2*WIDTH-1:WIDTH]),
    .quot      (acc[WIDTH-1:0]),
    .divisor   (b_mag),
    .rem_next  (rem_next),
    .quot_next (quot_next)
  );

  // Multiply: upper half accumulates partial products, lower half shifts the multiplier out.
  always_comb begin
    mult_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? b_mag : '0)};
    acc_next  = (op == OP_MULT) ? {mult_sum, acc[WIDTH-1:1]} : {rem_next, quot_next};
    prod      = sign_wide(acc_next, neg);
    final_res = '0;
    final_exc = 1'b0;
    if (op == OP_MULT) begin
      final_res = prod[WIDTH-1:0];
      final_exc = wide_ovf(prod);
    end else if (zero_div) begin
      final_res = '0;
      final_exc = 1'b1;
    end else begin
      final_res = negate_if(quot_next, neg);
      final_exc = ~neg & quot_next[WIDTH-1];
    end
  end

  // Operand/datapath registers: loaded on start, iterated in RUN, no reset needed.
  always_ff @(posedge clock) begin
    if (start) begin
      op       <= mult ? OP_MULT : OP_DIV;
      neg      <= operandA[WIDTH-1] ^ operandB[WIDTH-1];
      zero_div <= (operandB == '0);
      if (mult) begin
        b_mag <= magnitude(operandA);
        acc   <= {{WIDTH{1'b0}}, magnitude(operandB)};
      end else begin
        b_mag <= magnitude(operandB);
        acc   <= {{WIDTH{1'b0}}, magnitude(operandA)};
      end
    end else if (state == RUN) begin
      acc <= acc_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= '0;
      result    <= '0;
      resultRDY <= 1'b0;
      exception <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          resultRDY <= 1'b0;
          if (mult ^ div) begin
            state <= RUN;
            count <= '0;
          end
        end
        RUN: begin
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            state     <= DONE;
            result    <= final_res;
            exception <= final_exc;
            resultRDY <= 1'b1;
          end
        end
        DONE: begin
          resultRDY <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
